tournament_branch_predictor: RTL
================================

Name: tournament_branch_predictor

Overview:
Next-generation front-end direction/target predictor. Combines a gshare table, a PC-indexed bimodal table and a per-PC chooser into a tournament predictor, backed by a set-associative BTB with round-robin replacement. Fetch receives same-cycle predictions. Retire drives training and corrected-history recovery.

Parameters:
GH, 8, global history bits; 2 <= GH <= PHT_BITS, enforced by an elaboration check
PHT_BITS, 10, gshare table entries = 2^PHT_BITS
BIM_BITS, 10, bimodal table entries = 2^BIM_BITS
CHO_BITS, 10, chooser table entries = 2^CHO_BITS
CTR_BITS, 2, width of every saturating counter; must be >= 2
BTB_SET_BITS, 6, BTB sets = 2^BTB_SET_BITS
BTB_WAYS, 2, BTB associativity; 1..8

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
predict_req_valid_i  in  1  lookup valid
predict_req_pc_i  in  32  lookup PC
predict_req_used_i  in  1  fetch consumes prediction; shift GHR
predict_taken_o  out  1  final direction
predict_target_o  out  32  BTB target; 0 unless predict_btb_hit_o
predict_btb_hit_o  out  1  valid && taken && tag hit in any way
predict_provider_o  out  1  1 = gshare chose, 0 = bimodal
predict_ghr_snapshot_o  out  GH  GHR used for this lookup
train_valid_i  in  1  resolved branch update
train_pc_i  in  32  resolved PC
train_actual_taken_i  in  1  resolved direction
train_actual_target_i  in  32  resolved target
train_ghr_snapshot_i  in  GH  snapshot from prediction time
recover_mispredict_pulse_i  in  1  restore GHR
recover_ghr_snapshot_i  in  GH  snapshot of the mispredicted branch
recover_taken_i  in  1  corrected outcome of that branch

Behaviour:
- Indices:
  - gshare = pc[2+:PHT_BITS] ^ zero-extended GHR (predict) or train snapshot (train).
  - bimodal = pc[2+:BIM_BITS]; chooser = pc[2+:CHO_BITS].
  - BTB set = pc[2+:BTB_SET_BITS]; tag = pc[31:2+BTB_SET_BITS].
- Reset (async):
  - GHR = 0.
  - gshare/bimodal counters = 2^(CTR_BITS-1)-1 (weak not-taken).
  - Chooser counters = 2^(CTR_BITS-1) (weak gshare).
  - All BTB ways invalid; all victim pointers = 0.
  - Outputs follow from these values: taken=0, hit=0, target=0, provider=1 while reset is held.
- Predict (combinational, zero latency):
  - Component prediction = counter MSB; chooser MSB selects gshare.
  - If !predict_req_valid_i: taken, hit and target are 0; provider and snapshot are still driven.
  - predict_ghr_snapshot_o = current GHR.
  - Lookups never modify table state.
- GHR update, per edge, priority order:
  1. recover: GHR <= {recover_ghr_snapshot_i[GH-2:0], recover_taken_i}.
  2. else valid && used: GHR <= {GHR[GH-2:0], predict_taken_o}.
  3. else hold.
- Train (one edge, read-before-write):
  - Both component counters saturate toward the outcome: increment capped at all-ones, decrement floored at 0.
  - Chooser updates only when gshare and bimodal disagree: +1 (sat) if gshare was correct, -1 (sat) if bimodal was correct.
  - Component predictions for the chooser come from the pre-update table values.
- BTB train, only when taken:
  - Tag hit in a way: rewrite that way's target.
  - Miss: allocate the lowest-index invalid way; if none, allocate the way at the set's victim pointer, then advance the pointer modulo BTB_WAYS.
  - Not-taken training leaves the BTB untouched.
- Simultaneous events:
  - Predict and train to the same entry in one cycle: predict sees the old value; the update is visible next cycle.
  - Train and recover in one cycle: both take effect.
  - Multiple matching ways (must not occur): the lowest index wins.
- Reset asserted mid-operation: all state clears immediately; in-flight train is discarded.

Optional Feature:
BP_STATS_EN:
- Defined: adds three 32-bit outputs, all reset to 0 and saturating at 32'hFFFF_FFFF:
  - stat_lookups_o: increments on valid && used.
  - stat_recovers_o: increments on each recover pulse.
  - stat_btb_miss_o: increments when valid && predict_taken_o && !predict_btb_hit_o.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup PC 0x1000 -> taken=0, hit=0, target=0, provider=1, snapshot=0.
- Train PC 0x1000 taken, target 0x2000, twice with snapshot 0 (GHR 0) -> next lookup: taken=1, hit=1, target=0x2000.
- With BTB_WAYS=2, train taken PCs 0x0000, 0x0100, 0x0200 (same set, 64 sets) -> 0x0000 evicted, 0x0100 and 0x0200 hit; a 4th PC 0x0300 evicts 0x0100.
- Five valid+used lookups predicting taken=1, then recover with snapshot 8'h0F and taken=0 -> next snapshot = 8'h1E; recover in the same cycle as a used lookup -> recover value wins.
- Alternating T/N branch at fixed GHR patterns: gshare is correct and bimodal wrong -> chooser saturates to 3, provider=1; when components agree, chooser is unchanged.
- Drive a counter to 3 and train taken again -> stays 3; drive to 0 and train not-taken -> stays 0; assert reset mid-train -> all state back to reset values.

Source files
------------

// File: rtl/tournament_branch_predictor.sv
// Tournament branch predictor: gshare + bimodal direction tables arbitrated by a
// per-PC chooser, plus a set-associative BTB with per-set round-robin victims.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   predict_req_*                same-cycle lookup (valid, pc, used -> shift GHR)
//   predict_*_o                  direction, BTB target/hit, provider, GHR snapshot
//   train_*                      retire-time update of counters, chooser and BTB
//   recover_*                    GHR restore from a mispredicted branch's snapshot
//   stat_*_o                     saturating event counters, only with BP_STATS_EN
//
// Build option: define BP_STATS_EN to add the three statistics outputs.
module tournament_branch_predictor #(
  parameter int unsigned GH           = 8,
  parameter int unsigned PHT_BITS     = 10,
  parameter int unsigned BIM_BITS     = 10,
  parameter int unsigned CHO_BITS     = 10,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned BTB_SET_BITS = 6,
  parameter int unsigned BTB_WAYS     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                predict_req_valid_i,
  input  logic [31:0]         predict_req_pc_i,
  input  logic                predict_req_used_i,
  output logic                predict_taken_o,
  output logic [31:0]         predict_target_o,
  output logic                predict_btb_hit_o,
  output logic                predict_provider_o,
  output logic [GH-1:0]       predict_ghr_snapshot_o,
  input  logic                train_valid_i,
  input  logic [31:0]         train_pc_i,
  input  logic                train_actual_taken_i,
  input  logic [31:0]         train_actual_target_i,
  input  logic [GH-1:0]       train_ghr_snapshot_i,
  input  logic                recover_mispredict_pulse_i,
  input  logic [GH-1:0]       recover_ghr_snapshot_i,
  input  logic                recover_taken_i
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_lookups_o,
  output logic [31:0]         stat_recovers_o,
  output logic [31:0]         stat_btb_miss_o
`endif
);

  localparam int unsigned PHT_N = 1 << PHT_BITS;
  localparam int unsigned BIM_N = 1 << BIM_BITS;
  localparam int unsigned CHO_N = 1 << CHO_BITS;
  localparam int unsigned SETS  = 1 << BTB_SET_BITS;
  localparam int unsigned TAG_W = 30 - BTB_SET_BITS;
  localparam int unsigned WAY_W = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_G  = {1'b1, {(CTR_BITS-1){1'b0}}};

  generate
    if (GH < 2 || GH > PHT_BITS) begin : g_bad_gh
      $error("GH must satisfy 2 <= GH <= PHT_BITS");
    end
    if (CTR_BITS < 2) begin : g_bad_ctr
      $error("CTR_BITS must be >= 2");
    end
    if (BTB_WAYS < 1 || BTB_WAYS > 8) begin : g_bad_ways
      $error("BTB_WAYS must be in 1..8");
    end
  endgenerate

  // State
  logic [GH-1:0]       ghr;
  logic [CTR_BITS-1:0] pht [PHT_N];
  logic [CTR_BITS-1:0] bim [BIM_N];
  logic [CTR_BITS-1:0] cho [CHO_N];
  logic                btb_val [SETS][BTB_WAYS];
  logic [TAG_W-1:0]    btb_tag [SETS][BTB_WAYS];
  logic [31:0]         btb_tgt [SETS][BTB_WAYS];
  logic [WAY_W-1:0]    vptr    [SETS];

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == '1) ? c : c + 1'b1;
    else    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Predict path
  logic [PHT_BITS-1:0]     p_pht_idx;
  logic [BIM_BITS-1:0]     p_bim_idx;
  logic [CHO_BITS-1:0]     p_cho_idx;
  logic [BTB_SET_BITS-1:0] p_set;
  logic [TAG_W-1:0]        p_tag;
  logic                    p_g, p_b, p_c, p_dir, p_any;
  logic [31:0]             p_tgt;

  assign p_pht_idx = predict_req_pc_i[2 +: PHT_BITS] ^ PHT_BITS'(ghr);
  assign p_bim_idx = predict_req_pc_i[2 +: BIM_BITS];
  assign p_cho_idx = predict_req_pc_i[2 +: CHO_BITS];
  assign p_set     = predict_req_pc_i[2 +: BTB_SET_BITS];
  assign p_tag     = predict_req_pc_i[31:2+BTB_SET_BITS];

  assign p_g   = pht[p_pht_idx][CTR_BITS-1];
  assign p_b   = bim[p_bim_idx][CTR_BITS-1];
  assign p_c   = cho[p_cho_idx][CTR_BITS-1];
  assign p_dir = p_c ? p_g : p_b;

  always_comb begin
    p_any = 1'b0;
    p_tgt = '0;
    for (int unsigned w = 0; w < BTB_WAYS; w++) begin
      if (!p_any && btb_val[p_set][w] && btb_tag[p_set][w] == p_tag) begin
        p_any = 1'b1;
        p_tgt = btb_tgt[p_set][w];
      end
    end
  end

  assign predict_taken_o        = predict_req_valid_i & p_dir;
  assign predict_btb_hit_o      = predict_taken_o & p_any;
  assign predict_target_o       = predict_btb_hit_o ? p_tgt : '0;
  assign predict_provider_o     = p_c;
  assign predict_ghr_snapshot_o = ghr;

  // Train path (reads pre-update table contents)
  logic [PHT_BITS-1:0]     t_pht_idx;
  logic [BIM_BITS-1:0]     t_bim_idx;
  logic [CHO_BITS-1:0]     t_cho_idx;
  logic [BTB_SET_BITS-1:0] t_set;
  logic [TAG_W-1:0]        t_tag;
  logic                    t_g, t_b, t_cho_we;
  logic [CTR_BITS-1:0]     t_pht_next, t_bim_next, t_cho_next;
  logic                    t_hit, t_inv;
  logic [WAY_W-1:0]        t_hit_way, t_inv_way, t_way, t_vptr_next;

  assign t_pht_idx = train_pc_i[2 +: PHT_BITS] ^ PHT_BITS'(train_ghr_snapshot_i);
  assign t_bim_idx = train_pc_i[2 +: BIM_BITS];
  assign t_cho_idx = train_pc_i[2 +: CHO_BITS];
  assign t_set     = train_pc_i[2 +: BTB_SET_BITS];
  assign t_tag     = train_pc_i[31:2+BTB_SET_BITS];

  assign t_g        = pht[t_pht_idx][CTR_BITS-1];
  assign t_b        = bim[t_bim_idx][CTR_BITS-1];
  assign t_pht_next = sat_step(pht[t_pht_idx], train_actual_taken_i);
  assign t_bim_next = sat_step(bim[t_bim_idx], train_actual_taken_i);
  // On disagreement exactly one component is right; move toward gshare if it was.
  assign t_cho_we   = t_g != t_b;
  assign t_cho_next = sat_step(cho[t_cho_idx], t_g == train_actual_taken_i);

  always_comb begin
    t_hit     = 1'b0;
    t_hit_way = '0;
    t_inv     = 1'b0;
    t_inv_way = '0;
    for (int unsigned w = 0; w < BTB_WAYS; w++) begin
      if (!t_hit && btb_val[t_set][w] && btb_tag[t_set][w] == t_tag) begin
        t_hit     = 1'b1;
        t_hit_way = WAY_W'(w);
      end
      if (!t_inv && !btb_val[t_set][w]) begin
        t_inv     = 1'b1;
        t_inv_way = WAY_W'(w);
      end
    end
  end

  assign t_way       = t_hit ? t_hit_way : (t_inv ? t_inv_way : vptr[t_set]);
  assign t_vptr_next = (vptr[t_set] == WAY_W'(BTB_WAYS - 1)) ? '0 : vptr[t_set] + 1'b1;

  // Global history: recovery overrides a concurrent speculative shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (recover_mispredict_pulse_i) begin
      ghr <= {recover_ghr_snapshot_i[GH-2:0], recover_taken_i};
    end else if (predict_req_valid_i && predict_req_used_i) begin
      ghr <= {ghr[GH-2:0], predict_taken_o};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= CTR_WEAK_NT;
      for (int unsigned i = 0; i < BIM_N; i++) bim[i] <= CTR_WEAK_NT;
      for (int unsigned i = 0; i < CHO_N; i++) cho[i] <= CTR_WEAK_G;
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr[s] <= '0;
        for (int unsigned w = 0; w < BTB_WAYS; w++) begin
          btb_val[s][w] <= 1'b0;
          btb_tag[s][w] <= '0;
          btb_tgt[s][w] <= '0;
        end
      end
    end else if (train_valid_i) begin
      pht[t_pht_idx] <= t_pht_next;
      bim[t_bim_idx] <= t_bim_next;
      if (t_cho_we) cho[t_cho_idx] <= t_cho_next;
      if (train_actual_taken_i) begin
        btb_val[t_set][t_way] <= 1'b1;
        btb_tag[t_set][t_way] <= t_tag;
        btb_tgt[t_set][t_way] <= train_actual_target_i;
        if (!t_hit && !t_inv) vptr[t_set] <= t_vptr_next;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_lookups_o  <= '0;
      stat_recovers_o <= '0;
      stat_btb_miss_o <= '0;
    end else begin
      if (predict_req_valid_i && predict_req_used_i && stat_lookups_o != '1)
        stat_lookups_o <= stat_lookups_o + 1'b1;
      if (recover_mispredict_pulse_i && stat_recovers_o != '1)
        stat_recovers_o <= stat_recovers_o + 1'b1;
      if (predict_taken_o && !predict_btb_hit_o && stat_btb_miss_o != '1)
        stat_btb_miss_o <= stat_btb_miss_o + 1'b1;
    end
  end
`endif

  // Byte-offset bits and the snapshot MSB shifted out on recovery carry no information.
  logic unused_bits;
  assign unused_bits = ^{predict_req_pc_i[1:0], train_pc_i[1:0], recover_ghr_snapshot_i[GH-1]};

endmodule
